fifo_write_arbiter: RTL and testbench

- Round-robin arbiter sharing the single write port of a synchronous FIFO among NUM_REQ requesters.
- Grants one requester at a time for a burst of up to MAX_BURST words.
- Drives the FIFO's w_en/data_in and honours its full flag.
- Sits directly in front of the FIFO write side. Read side is untouched.

---
 rtl/fifo_write_arbiter.sv | 138 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that shares the single write port of a synchronous
//   FIFO among NUM_REQ requesters. The winner owns the port for a burst of up
//   to MAX_BURST words. It can release the port early by dropping its request.
//   Words are never pushed while the FIFO reports full.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   req_i           per-requester write request (held while data is pending)
//   req_data_i      packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full_i     FIFO full flag
//   gnt_o           registered one-hot grant
//   fifo_w_en_o     FIFO write enable (accepted beat)
//   fifo_data_in_o  FIFO write data (owner's slice)
//   owner_id_o      index of the current or last owner
//   busy_o          high while a burst is in progress
//
// state | meaning
// IDLE  | no owner; pick the next requester starting at rr_ptr
// BURST | owner_id holds the write port until burst end or early release
module fifo_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_BURST   = 4,
  parameter int BURST_WIDTH = 3,
  parameter int ID_WIDTH    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic                          fifo_full_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          fifo_w_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_in_o,
  output logic [ID_WIDTH-1:0]           owner_id_o,
  output logic                          busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic [BURST_WIDTH-1:0] LastBeat = BURST_WIDTH'(MAX_BURST - 1);

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [ID_WIDTH-1:0]     owner_q, owner_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BURST_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

  logic                    pick_valid;
  logic [ID_WIDTH-1:0]     pick_id;
  logic                    owner_req;
  logic                    accept;

  // Index arithmetic wraps at NUM_REQ, which need not be a power of two.
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                   input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_WIDTH'(s);
  endfunction

  // Walk offsets from the highest down so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[wrap_add(rr_ptr_q, i)]) begin
        pick_valid = 1'b1;
        pick_id    = wrap_add(rr_ptr_q, i);
      end
    end
  end

  assign owner_req = req_i[owner_q];
  assign accept    = (state_q == BURST) && owner_req && !fifo_full_i;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          owner_d    = pick_id;
          gnt_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        // Early release and last accepted beat both hand the port back.
        if (!owner_req || (accept && beat_cnt_q == LastBeat)) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = wrap_add(owner_q, 1);
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign gnt_o          = gnt_q;
  assign fifo_w_en_o    = accept;
  assign fifo_data_in_o = req_data_i[int'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
  assign owner_id_o     = owner_q;
  assign busy_o         = (state_q == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: expected {owner, word} pairs are
// queued per scenario and popped whenever the arbiter writes to the FIFO.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        full;
  logic [3:0]  gnt;
  logic        fifo_w_en;
  logic [7:0]  data_in;
  logic [1:0]  owner_id;
  logic        busy;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cnt[4];
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  fifo_write_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .req_data_i     (req_data),
    .fifo_full_i    (full),
    .gnt_o          (gnt),
    .fifo_w_en_o    (fifo_w_en),
    .fifo_data_in_o (data_in),
    .owner_id_o     (owner_id),
    .busy_o         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Word k of requester i; requester 1 starts at 0xA0.
  function automatic logic [7:0] word(input int i, input int k);
    return 8'(32'h60 + i * 64 + k);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = word(i, cnt[i]);
  endtask

  task automatic push(input int i, input int k);
    sb.push_back(32'((i << 8) | int'(word(i, k))));
  endtask

  // One clock: check the write port at negedge, then advance requester data.
  task automatic cycle();
    logic [3:0]  cons;
    logic [31:0] e;
    @(negedge clk);
    chk("wen_while_full", 32'(fifo_w_en & full), 32'h0);
    if (fifo_w_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {22'b0, owner_id, data_in}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("write", {22'b0, owner_id, data_in}, e);
      end
    end
    cons = gnt & req & {4{~full}};
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (cons[i]) cnt[i]++;
    drive_data();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0;
    full  = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    drive_data();
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with random activity on the inputs.
    rst_n = 1'b0;
    req   = 4'b0;
    full  = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    drive_data();
    for (int n = 0; n < 6; n++) begin
      req  = 4'($urandom_range(0, 15));
      full = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_wen", 32'(fifo_w_en), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_owner", 32'(owner_id), 32'h0);
      chk("rst_data", 32'(data_in), 32'(word(0, 0)));
    end
    req  = 4'b0;
    full = 1'b0;
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cycle();
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
    end

    // Single requester: burst of 4, one arbitration cycle, regrant to 1.
    do_reset();
    chk("single_pre_gnt", 32'(gnt), 32'h0);
    req = 4'b0010;
    for (int k = 0; k < 7; k++) push(1, k);
    cycle();
    chk("single_gnt", 32'(gnt), 32'h2);
    repeat (4) cycle();
    chk("single_end_busy", 32'(busy), 32'h0);
    chk("single_end_gnt", 32'(gnt), 32'h0);
    cycle();
    chk("single_regnt", 32'(gnt), 32'h2);
    chk("single_reowner", 32'(owner_id), 32'h1);
    repeat (3) cycle();
    req = 4'b0;
    repeat (2) cycle();
    chk("single_sb_empty", 32'(sb.size()), 32'h0);

    // Fairness and throughput: bursts every 5 cycles, owners 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    for (int o = 0; o < 4; o++) for (int k = 0; k < 4; k++) push(o, k);
    for (int k = 4; k < 8; k++) push(0, k);
    for (int c = 1; c <= 25; c++) begin
      cycle();
      if (c % 5 == 1) chk("fair_owner", 32'(owner_id), 32'(((c - 1) / 5) % 4));
    end
    req = 4'b0;
    chk("fair_sb_empty", 32'(sb.size()), 32'h0);
    repeat (2) cycle();

    // Back-pressure after the second beat.
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 4; k++) push(0, k);
    repeat (3) cycle();
    full = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("bp_gnt_held", 32'(gnt), 32'h1);
      chk("bp_busy", 32'(busy), 32'h1);
    end
    full = 1'b0;
    repeat (2) cycle();
    req = 4'b0;
    chk("bp_end_busy", 32'(busy), 32'h0);
    chk("bp_end_gnt", 32'(gnt), 32'h0);
    repeat (2) cycle();
    chk("bp_sb_empty", 32'(sb.size()), 32'h0);

    // Early release by requester 2, then rr_ptr points at 3.
    do_reset();
    req = 4'b0100;
    push(2, 0);
    push(2, 1);
    push(3, 0);
    repeat (3) cycle();
    req = 4'b0;
    cycle();
    chk("er_idle_busy", 32'(busy), 32'h0);
    req = 4'b1001;
    cycle();
    chk("er_next_owner", 32'(owner_id), 32'h3);
    chk("er_next_gnt", 32'(gnt), 32'h8);
    cycle();
    req = 4'b0;
    repeat (2) cycle();
    chk("er_sb_empty", 32'(sb.size()), 32'h0);

    // Async reset mid-burst with a non-zero rr_ptr beforehand.
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 4; k++) push(0, k);
    push(2, 0);
    push(0, 4);
    repeat (5) cycle();
    req = 4'b0101;
    cycle();
    chk("ar_pre_owner", 32'(owner_id), 32'h2);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 32'h0);
    chk("ar_wen", 32'(fifo_w_en), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_owner", 32'(owner_id), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    cycle();
    chk("ar_restart_owner", 32'(owner_id), 32'h0);
    chk("ar_restart_gnt", 32'(gnt), 32'h1);
    cycle();
    req = 4'b0;
    repeat (2) cycle();
    chk("ar_sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
